// File: rtl/dmem_responder.sv
// Memory-side responder for the LC3 dmem bus: word-addressed RAM with a programmable access latency.
// Optional DMEM_RAND_WAIT_EN adds an LFSR-driven 0..3 cycle extra wait per access.
module dmem_responder #(
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        mem_access,
  input  logic        data_rd,
  input  logic [15:0] data_addr,
  input  logic [15:0] data_din,
  output logic [15:0] data_dout,
  output logic        complete_data,
  output logic        addr_err,
  output logic [1:0]  fsm_state_o
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_DONE    = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  state_t              state_q;
  logic [3:0]          cnt_q;
  logic                rd_q;
  logic [15:0]         addr_q;
  logic [15:0]         din_q;
  logic [15:0]         dout_q;
  logic                complete_q;
  logic                err_q;
  logic [15:0]         mem [DEPTH];

  logic                in_range;
  logic [ADDR_W-1:0]   idx;
  logic                mem_we;
  logic [3:0]          load_val;
  logic                capture;

  assign capture  = (state_q == S_IDLE) && mem_access;
  assign in_range = ((addr_q >> ADDR_W) == 16'd0);
  assign idx      = addr_q[ADDR_W-1:0];

`ifdef DMEM_RAND_WAIT_EN
  logic [7:0] lfsr_q;
  logic [4:0] wait_sum;

  assign wait_sum = 5'(LATENCY) + {3'b000, lfsr_q[1:0]};
  assign load_val = (wait_sum > 5'd15) ? 4'hF : wait_sum[3:0];

  // Taps 8,6,5,4; advances only on capture so the wait sequence is repeatable after reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      lfsr_q <= 8'hA5;
    end else if (capture) begin
      lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end
  end
`else
  assign load_val = 4'(LATENCY);
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      rd_q       <= 1'b1;
      addr_q     <= 16'd0;
      din_q      <= 16'd0;
      dout_q     <= 16'h0000;
      complete_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      complete_q <= 1'b0;
      err_q      <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (mem_access) begin
            rd_q    <= data_rd;
            addr_q  <= data_addr;
            din_q   <= data_din;
            cnt_q   <= load_val;
            state_q <= (load_val == 4'd0) ? S_DONE : S_WAIT;
          end
        end
        S_WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q <= 4'd1) state_q <= S_DONE;
        end
        S_DONE: begin
          complete_q <= 1'b1;
          err_q      <= ~in_range;
          if (rd_q) dout_q <= in_range ? mem[idx] : 16'h0000;
          state_q    <= S_RELEASE;
        end
        S_RELEASE: begin
          // Held strobe must drop before another access can be captured.
          if (!mem_access) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Write commits on the DONE edge; a reset on that edge aborts it.
  assign mem_we = (state_q == S_DONE) && !rd_q && in_range && !reset;

  always_ff @(posedge clock) begin
    if (mem_we) mem[idx] <= din_q;
  end

  assign data_dout     = dout_q;
  assign complete_data = complete_q;
  assign addr_err      = err_q;
  assign fsm_state_o   = state_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (LATENCY=2 and LATENCY=0) share the bus inputs but
// have separate strobes; a reference memory model feeds per-instance expected queues.
module tb_dmem_responder;

  localparam int ADDR_W = 8;
  localparam int EW     = 49;  // {expected completion cycle[31:0], addr_err, data[15:0]}

  // clock / reset
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset;
  logic [1:0]  mem_access;
  logic        data_rd;
  logic [15:0] data_addr;
  logic [15:0] data_din;
  logic [15:0] dout [2];
  logic        cmp  [2];
  logic        aerr [2];
  logic [1:0]  st   [2];

  int unsigned cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  dmem_responder #(.ADDR_W(ADDR_W), .LATENCY(2)) u_dut_l2 (
    .clock(clock), .reset(reset), .mem_access(mem_access[0]), .data_rd(data_rd),
    .data_addr(data_addr), .data_din(data_din), .data_dout(dout[0]),
    .complete_data(cmp[0]), .addr_err(aerr[0]), .fsm_state_o(st[0])
  );

  dmem_responder #(.ADDR_W(ADDR_W), .LATENCY(0)) u_dut_l0 (
    .clock(clock), .reset(reset), .mem_access(mem_access[1]), .data_rd(data_rd),
    .data_addr(data_addr), .data_din(data_din), .data_dout(dout[1]),
    .complete_data(cmp[1]), .addr_err(aerr[1]), .fsm_state_o(st[1])
  );

  // reference model
  int          lat_cfg [2] = '{2, 0};
  logic [15:0] ref_mem [2][256];
  logic [15:0] last_dout [2] = '{16'h0000, 16'h0000};
  logic [7:0]  lfsr_m [2] = '{8'hA5, 8'hA5};

  logic [EW-1:0] exp_q0[$];
  logic [EW-1:0] exp_q1[$];

  int chk_cnt  = 0;
  int pass_cnt = 0;

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s dut%0d: got %0h expected %0h (t=%0t)", name, idx, act, exp, $time);
  endtask

`ifdef DMEM_RAND_WAIT_EN
  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction
`endif

  task automatic push_expect(input int i, input logic rd, input logic [15:0] addr,
                             input logic [15:0] din, input int unsigned cap);
    logic        err;
    logic [15:0] d;
    int          tot;
    logic [31:0] due;
    err = (addr >= 16'(256));
    tot = lat_cfg[i];
`ifdef DMEM_RAND_WAIT_EN
    tot = tot + int'(lfsr_m[i][1:0]);
    lfsr_m[i] = lfsr_next(lfsr_m[i]);
`endif
    if (tot > 15) tot = 15;
    if (rd) begin
      d = err ? 16'h0000 : ref_mem[i][addr[7:0]];
    end else begin
      d = last_dout[i];
      if (!err) ref_mem[i][addr[7:0]] = din;
    end
    last_dout[i] = d;
    due = 32'(cap + 32'(tot) + 1);
    if (i == 0) exp_q0.push_back({due, err, d});
    else        exp_q1.push_back({due, err, d});
  endtask

  // driver tasks (entered and left on a negedge)
  task automatic apply_reset(input int n);
    reset = 1'b1;
    mem_access = 2'b00;
    repeat (n) @(negedge clock);
    for (int i = 0; i < 2; i++) begin
      check("reset_complete", i, 32'(cmp[i]), 32'd0);
      check("reset_dout", i, 32'(dout[i]), 32'h0000);
      check("reset_addr_err", i, 32'(aerr[i]), 32'd0);
      last_dout[i] = 16'h0000;
      lfsr_m[i] = 8'hA5;
    end
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic do_access(input logic [1:0] mask, input logic rd, input logic [15:0] addr,
                           input logic [15:0] din, input int hold);
    logic [1:0] done;
    int budget;
    data_rd = rd;
    data_addr = addr;
    data_din = din;
    mem_access = mask;
    for (int i = 0; i < 2; i++) if (mask[i]) push_expect(i, rd, addr, din, cyc + 1);
    done = ~mask;
    budget = 0;
    while (done != 2'b11 && budget < 40) begin
      @(negedge clock);
      budget++;
      if (budget == 1) begin
        data_rd = 1'($urandom);
        data_addr = 16'($urandom);
        data_din = 16'($urandom);
      end
      for (int i = 0; i < 2; i++) if (cmp[i]) done[i] = 1'b1;
    end
    if (done != 2'b11) check("complete_timeout", 0, 32'(done), 32'd3);
    repeat (hold) @(negedge clock);
    mem_access = 2'b00;
    @(negedge clock);
  endtask

  // scoreboard monitor
  always @(negedge clock) begin
    for (int i = 0; i < 2; i++) begin
      logic [EW-1:0] e;
      if (cmp[i]) begin
        if ((i == 0 && exp_q0.size() == 0) || (i == 1 && exp_q1.size() == 0)) begin
          check("unexpected_complete", i, 32'd1, 32'd0);
        end else begin
          e = (i == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
          check("complete_cycle", i, cyc, e[48:17]);
          check("addr_err", i, 32'(aerr[i]), 32'(e[16]));
          check("data_dout", i, 32'(dout[i]), 32'(e[15:0]));
        end
      end else if (aerr[i]) begin
        check("stray_addr_err", i, 32'd1, 32'd0);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    mem_access = 2'b00;
    data_rd = 1'b1;
    data_addr = 16'h0000;
    data_din = 16'h0000;
    apply_reset(3);

    for (int a = 0; a < 256; a++) do_access(2'b11, 1'b0, 16'(a), 16'($urandom), 0);

    // write then read back
    do_access(2'b11, 1'b0, 16'h0010, 16'hBEEF, 0);
    do_access(2'b11, 1'b1, 16'h0010, 16'h0000, 0);
    check("readback_beef", 0, 32'(dout[0]), 32'h0000BEEF);

    // held strobe yields a single completion
    do_access(2'b11, 1'b1, 16'h0003, 16'h0000, 10);

    // out of range read and dropped write
    do_access(2'b11, 1'b1, 16'h0100, 16'h0000, 0);
    do_access(2'b11, 1'b0, 16'h0100, 16'h1234, 0);
    do_access(2'b11, 1'b1, 16'h0000, 16'h0000, 1);

    // reset during WAIT aborts the write (LATENCY=2 instance only)
    data_rd = 1'b0;
    data_addr = 16'h0020;
    data_din = 16'h5555;
    mem_access = 2'b01;
    @(negedge clock);
    @(negedge clock);
    apply_reset(1);
    repeat (6) @(negedge clock);
    do_access(2'b11, 1'b1, 16'h0020, 16'h0000, 0);

    // zero-latency read-after-write at top address
    do_access(2'b11, 1'b0, 16'h00FF, 16'hA0A0, 0);
    do_access(2'b11, 1'b1, 16'h00FF, 16'h0000, 0);
    check("readback_a0a0", 1, 32'(dout[1]), 32'h0000A0A0);

    // randomized traffic
    for (int n = 0; n < 200; n++) begin
      logic [15:0] a;
      a = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(0, 255));
      do_access(2'($urandom_range(1, 3)), 1'($urandom), a, 16'($urandom), $urandom_range(0, 3));
    end

    // two reset runs of eight reads each; wait sequence must restart identically
    for (int r = 0; r < 2; r++) begin
      apply_reset(2);
      for (int n = 0; n < 8; n++) do_access(2'b11, 1'b1, 16'($urandom_range(0, 255)), 16'h0000, 0);
    end

    repeat (5) @(negedge clock);
    check("queue_drained", 0, 32'(exp_q0.size()), 32'd0);
    check("queue_drained", 1, 32'(exp_q1.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
